// File: rtl/mac_dot_sequencer_if.sv
// Operand, multiplier and result bundle for mac_dot_sequencer (slave = sequencer side).
// Multiplier structs live in the package so the sequencer and the multiplier share one layout.
package mac_dot_sequencer_pkg;
  typedef struct packed {
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] w;
    logic       dv;
  } mult_in_t;

  typedef struct packed {
    logic [15:0] data1;
    logic [15:0] data2;
    logic        dv;
  } mult_out_t;
endpackage

interface mac_dot_sequencer_if #(
  parameter int LEN_BIT_W = 16,
  parameter int ACC_BIT_W = 32
);
  import mac_dot_sequencer_pkg::*;

  logic                        start;
  logic [LEN_BIT_W-1:0]        len;
  logic                        busy;
  logic                        in_vld;
  logic                        in_rdy;
  logic signed [7:0]           a1;
  logic signed [7:0]           a2;
  logic signed [7:0]           w;
  mult_in_t                    mult_in;
  mult_out_t                   mult_out;
  logic                        res_vld;
  logic                        res_rdy;
  logic signed [ACC_BIT_W-1:0] sum1;
  logic signed [ACC_BIT_W-1:0] sum2;
  logic                        err;

  modport master (
    output start, len, in_vld, a1, a2, w, mult_out, res_rdy,
    input  busy, in_rdy, mult_in, res_vld, sum1, sum2, err
  );

  modport slave (
    input  start, len, in_vld, a1, a2, w, mult_out, res_rdy,
    output busy, in_rdy, mult_in, res_vld, sum1, sum2, err
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// N-beat dual-int8 dot-product sequencer: accept->mult_in 1 cycle, result 1 cycle after last product.
// in_rdy drops after the Nth accept; result held until res_rdy. MAC_SAT_EN selects saturating accumulate.
module mac_dot_sequencer
  import mac_dot_sequencer_pkg::*;
#(
  parameter int LEN_BIT_W = 16,
  parameter int ACC_BIT_W = 32,
  parameter int LAT       = 6
) (
  input logic              clk,
  input logic              rst_n,
  mac_dot_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int TMO_W = $clog2(2 * LAT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(2 * LAT - 1);

  state_t                      state;
  logic [LEN_BIT_W-1:0]        len_q;
  logic [LEN_BIT_W-1:0]        issue_cnt;
  logic [LEN_BIT_W-1:0]        recv_cnt;
  logic [TMO_W-1:0]            tmo_cnt;
  logic signed [ACC_BIT_W-1:0] acc1;
  logic signed [ACC_BIT_W-1:0] acc2;
  logic signed [ACC_BIT_W-1:0] acc1_nxt;
  logic signed [ACC_BIT_W-1:0] acc2_nxt;
  logic signed [15:0]          prod1;
  logic signed [15:0]          prod2;
  logic                        sat_evt;
  logic                        in_rdy_q;
  logic                        res_vld_q;
  logic                        busy_q;
  logic                        err_q;
  mult_in_t                    mult_in_q;
  logic                        accept;
  logic                        take;
  logic                        stray;

  assign prod1  = bus.mult_out.data1;
  assign prod2  = bus.mult_out.data2;
  assign accept = bus.in_vld & in_rdy_q;
  // Products only count while a job still expects them; DONE freezes the sums it is presenting.
  assign take   = bus.mult_out.dv && (state == ISSUE || state == DRAIN) && (recv_cnt != len_q);
  assign stray  = bus.mult_out.dv && !take;

`ifdef MAC_SAT_EN
  localparam logic signed [ACC_BIT_W-1:0] ACC_MAX = {1'b0, {(ACC_BIT_W-1){1'b1}}};
  localparam logic signed [ACC_BIT_W-1:0] ACC_MIN = {1'b1, {(ACC_BIT_W-1){1'b0}}};
  logic signed [ACC_BIT_W:0] wide1;
  logic signed [ACC_BIT_W:0] wide2;
  logic                      ovf1;
  logic                      ovf2;

  always_comb begin
    wide1    = (ACC_BIT_W+1)'(acc1) + (ACC_BIT_W+1)'(prod1);
    wide2    = (ACC_BIT_W+1)'(acc2) + (ACC_BIT_W+1)'(prod2);
    ovf1     = wide1[ACC_BIT_W] ^ wide1[ACC_BIT_W-1];
    ovf2     = wide2[ACC_BIT_W] ^ wide2[ACC_BIT_W-1];
    acc1_nxt = ovf1 ? (wide1[ACC_BIT_W] ? ACC_MIN : ACC_MAX) : wide1[ACC_BIT_W-1:0];
    acc2_nxt = ovf2 ? (wide2[ACC_BIT_W] ? ACC_MIN : ACC_MAX) : wide2[ACC_BIT_W-1:0];
    sat_evt  = ovf1 | ovf2;
  end
`else
  assign acc1_nxt = acc1 + ACC_BIT_W'(prod1);
  assign acc2_nxt = acc2 + ACC_BIT_W'(prod2);
  assign sat_evt  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      tmo_cnt   <= '0;
      acc1      <= '0;
      acc2      <= '0;
      in_rdy_q  <= 1'b0;
      res_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      mult_in_q <= '0;
    end else begin
      mult_in_q.dv <= 1'b0;
      if (take) begin
        acc1     <= acc1_nxt;
        acc2     <= acc2_nxt;
        recv_cnt <= recv_cnt + LEN_BIT_W'(1);
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q     <= bus.len;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            tmo_cnt   <= '0;
            acc1      <= '0;
            acc2      <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            if (bus.len == '0) begin
              state     <= DONE;
              res_vld_q <= 1'b1;
            end else begin
              state    <= ISSUE;
              in_rdy_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (accept) begin
            mult_in_q <= '{a1: bus.a1, a2: bus.a2, w: bus.w, dv: 1'b1};
            issue_cnt <= issue_cnt + LEN_BIT_W'(1);
            if (issue_cnt + LEN_BIT_W'(1) == len_q) begin
              in_rdy_q <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          tmo_cnt <= take ? '0 : tmo_cnt + TMO_W'(1);
          if (take && (recv_cnt + LEN_BIT_W'(1) == len_q)) begin
            state     <= DONE;
            res_vld_q <= 1'b1;
          end else if (!take && tmo_cnt == TMO_LAST) begin
            err_q     <= 1'b1;
            state     <= DONE;
            res_vld_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.res_rdy) begin
            state     <= IDLE;
            res_vld_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed after the case so an error seen in the start cycle is not lost to the clear.
      if (stray || (take && sat_evt)) err_q <= 1'b1;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.in_rdy  = in_rdy_q;
  assign bus.mult_in = mult_in_q;
  assign bus.res_vld = res_vld_q;
  assign bus.sum1    = acc1;
  assign bus.sum2    = acc2;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Drives a 32-bit and a 16-bit accumulator sequencer in lockstep against a pipelined multiplier model.
// Expected sums are computed per job from the beat tables and queued until the result handshake.
module tb_mac_dot_sequencer;
  import mac_dot_sequencer_pkg::*;

  localparam int LEN_W = 16;
  localparam int LAT   = 6;
`ifdef MAC_SAT_EN
  localparam bit SAT_MODE = 1'b1;
`else
  localparam bit SAT_MODE = 1'b0;
`endif

  typedef struct {
    longint s1;
    longint s2;
    bit     err;
    longint t1;
    longint t2;
    bit     err16;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic kill_dv;
  logic inj_dv;
  mult_out_t pipe [LAT];
  mult_out_t mdl_out;
  exp_t sb[$];
  int ba1 [8];
  int ba2 [8];
  int bw  [8];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_dot_sequencer_if #(.LEN_BIT_W(LEN_W), .ACC_BIT_W(32)) bus ();
  mac_dot_sequencer_if #(.LEN_BIT_W(LEN_W), .ACC_BIT_W(16)) bus16 ();

  mac_dot_sequencer #(.LEN_BIT_W(LEN_W), .ACC_BIT_W(32), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  mac_dot_sequencer #(.LEN_BIT_W(LEN_W), .ACC_BIT_W(16), .LAT(LAT)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16)
  );

  assign bus16.start    = bus.start;
  assign bus16.len      = bus.len;
  assign bus16.in_vld   = bus.in_vld;
  assign bus16.a1       = bus.a1;
  assign bus16.a2       = bus.a2;
  assign bus16.w        = bus.w;
  assign bus16.res_rdy  = bus.res_rdy;
  assign bus.mult_out   = mdl_out;
  assign bus16.mult_out = mdl_out;

  // Fully pipelined multiplier, LAT register stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0].data1 <= 16'($signed(bus.mult_in.a1)) * 16'($signed(bus.mult_in.w));
      pipe[0].data2 <= 16'($signed(bus.mult_in.a2)) * 16'($signed(bus.mult_in.w));
      pipe[0].dv    <= bus.mult_in.dv & ~kill_dv;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    mdl_out    = pipe[LAT-1];
    mdl_out.dv = pipe[LAT-1].dv | inj_dv;
  end

  function automatic longint acc_step(input longint acc, input longint p, input int w, inout bit sat);
    longint s, hi, lo, span;
    bit ovf;
    span = longint'(1) <<< w;
    hi   = (span >>> 1) - 1;
    lo   = -(span >>> 1);
    s    = acc + p;
    ovf  = (s > hi) || (s < lo);
    if (ovf) begin
      if (SAT_MODE) s = (s > hi) ? hi : lo;
      else          s = (s > hi) ? s - span : s + span;
    end
    sat = sat | (SAT_MODE & ovf);
    return s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int a1, input int a2, input int w);
    for (int i = 0; i < 8; i++) begin
      ba1[i] = a1;
      ba2[i] = a2;
      bw[i]  = w;
    end
  endtask

  task automatic run_job(input string name, input int n, input bit toggle, input bit kill,
                         input int exp_lat, input int hold);
    exp_t e;
    bit s32, s16, took;
    int acc_cnt, cyc, lat;
    s32 = 1'b0;
    s16 = 1'b0;
    e = '{s1: 0, s2: 0, err: 1'b0, t1: 0, t2: 0, err16: 1'b0};
    for (int i = 0; i < n; i++) begin
      e.s1 = acc_step(e.s1, longint'(ba1[i] * bw[i]), 32, s32);
      e.s2 = acc_step(e.s2, longint'(ba2[i] * bw[i]), 32, s32);
      e.t1 = acc_step(e.t1, longint'(ba1[i] * bw[i]), 16, s16);
      e.t2 = acc_step(e.t2, longint'(ba2[i] * bw[i]), 16, s16);
    end
    e.err   = s32;
    e.err16 = s16;
    if (kill) e = '{s1: 0, s2: 0, err: 1'b1, t1: 0, t2: 0, err16: 1'b1};
    sb.push_back(e);

    kill_dv   = kill;
    bus.len   = LEN_W'(n);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    lat = 1;
    chk({name, ".busy"}, bus.busy, 1);
    chk({name, ".err_clr"}, bus.err, 0);
    chk({name, ".err16_clr"}, bus16.err, 0);

    acc_cnt = 0;
    cyc = 0;
    while (acc_cnt < n && cyc < 400) begin
      bus.in_vld = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.a1 = 8'(ba1[acc_cnt]);
      bus.a2 = 8'(ba2[acc_cnt]);
      bus.w  = 8'(bw[acc_cnt]);
      took = bus.in_vld & bus.in_rdy;
      tick;
      lat++;
      cyc++;
      chk({name, ".mult_dv"}, bus.mult_in.dv, took);
      if (took) acc_cnt++;
    end
    bus.in_vld = 1'b0;
    chk({name, ".accepted"}, acc_cnt, n);

    cyc = 0;
    while (!bus.res_vld && cyc < 200) begin
      tick;
      lat++;
      cyc++;
    end
    chk({name, ".res_vld"}, bus.res_vld, 1);
    chk({name, ".res_vld16"}, bus16.res_vld, 1);
    if (exp_lat >= 0) chk({name, ".latency"}, lat, exp_lat);

    e = sb.pop_front();
    chk({name, ".sum1"}, longint'(bus.sum1), e.s1);
    chk({name, ".sum2"}, longint'(bus.sum2), e.s2);
    chk({name, ".err"}, bus.err, e.err);
    chk({name, ".sum1_16"}, longint'(bus16.sum1), e.t1);
    chk({name, ".sum2_16"}, longint'(bus16.sum2), e.t2);
    chk({name, ".err_16"}, bus16.err, e.err16);

    for (int k = 0; k < hold; k++) begin
      bus.start = (k == 3);
      bus.len   = LEN_W'(5);
      tick;
      chk({name, ".hold_vld"}, bus.res_vld, 1);
      chk({name, ".hold_sum1"}, longint'(bus.sum1), e.s1);
    end
    bus.start   = 1'b0;
    bus.res_rdy = 1'b1;
    tick;
    bus.res_rdy = 1'b0;
    chk({name, ".post_vld"}, bus.res_vld, 0);
    chk({name, ".post_busy"}, bus.busy, 0);
    chk({name, ".post_rdy"}, bus.in_rdy, 0);
    kill_dv = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    kill_dv     = 1'b0;
    inj_dv      = 1'b0;
    bus.start   = 1'b0;
    bus.len     = '0;
    bus.in_vld  = 1'b0;
    bus.a1      = '0;
    bus.a2      = '0;
    bus.w       = '0;
    bus.res_rdy = 1'b0;
    repeat (3) tick;
    chk("rst.busy", bus.busy, 0);
    chk("rst.in_rdy", bus.in_rdy, 0);
    chk("rst.res_vld", bus.res_vld, 0);
    chk("rst.err", bus.err, 0);
    chk("rst.sum1", longint'(bus.sum1), 0);
    chk("rst.mult_in", longint'(bus.mult_in), 0);
    rst_n = 1'b1;
    tick;

    set_all(0, 0, 0);
    ba1[0] = 3; ba2[0] = -2; bw[0] = 5;
    run_job("single", 1, 1'b0, 1'b0, 9, 0);

    inj_dv = 1'b1;
    tick;
    inj_dv = 1'b0;
    chk("stray.err", bus.err, 1);
    chk("stray.err16", bus16.err, 1);
    chk("stray.sum1", longint'(bus.sum1), 15);

    set_all(127, -128, -128);
    run_job("extreme", 4, 1'b0, 1'b0, -1, 0);

    set_all(0, 0, 0);
    ba1[0] = 1; ba2[0] = 2; bw[0] = 3;
    ba1[1] = 4; ba2[1] = 5; bw[1] = 6;
    ba1[2] = 7; ba2[2] = 8; bw[2] = 9;
    run_job("toggle", 3, 1'b1, 1'b0, -1, 0);

    set_all(-7, 11, 13);
    run_job("backpressure", 2, 1'b0, 1'b0, -1, 10);

    run_job("zero_len", 0, 1'b0, 1'b0, -1, 0);

    set_all(5, 6, 7);
    run_job("timeout", 2, 1'b0, 1'b1, -1, 0);

    set_all(127, 127, 127);
    run_job("sat", 3, 1'b0, 1'b0, -1, 0);

    set_all(9, -9, 3);
    bus.len   = LEN_W'(8);
    bus.start = 1'b1;
    tick;
    bus.start  = 1'b0;
    bus.in_vld = 1'b1;
    bus.a1 = 8'sd9; bus.a2 = -8'sd9; bus.w = 8'sd3;
    repeat (3) tick;
    chk("mid.in_rdy_before", bus.in_rdy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid.busy", bus.busy, 0);
    chk("mid.in_rdy", bus.in_rdy, 0);
    chk("mid.mult_in", longint'(bus.mult_in), 0);
    chk("mid.res_vld", bus.res_vld, 0);
    chk("mid.sum2", longint'(bus.sum2), 0);
    bus.in_vld = 1'b0;
    tick;
    rst_n = 1'b1;
    repeat (LAT + 2) tick;
    chk("mid.idle_busy", bus.busy, 0);
    chk("mid.idle_rdy", bus.in_rdy, 0);
    chk("mid.idle_err", bus.err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
